// File: rtl/ctl_ammo_if.sv
// Ammo controller signal bundle.
//   new_frame   : one-cycle pulse at the start of each VGA frame
//   shot_fired  : one-cycle pulse per trigger pull
//   hit         : one-cycle pulse per successful hit
//   restart     : one-cycle reload request (acted on only while empty)
//   hex0 / hex1 : BCD ones / tens of the current ammo count
//   ammo_empty  : count is 00
//   game_over   : controller is in EMPTY
//   reloading   : controller is in RELOAD
//   reset_score : one-cycle pulse on EMPTY -> RELOAD
// master drives the event pulses and observes the display/flags; slave is the controller.
interface ctl_ammo_if;
  logic       new_frame;
  logic       shot_fired;
  logic       hit;
  logic       restart;
  logic [3:0] hex0;
  logic [3:0] hex1;
  logic       ammo_empty;
  logic       game_over;
  logic       reloading;
  logic       reset_score;

  modport master (
    output new_frame, shot_fired, hit, restart,
    input  hex0, hex1, ammo_empty, game_over, reloading, reset_score
  );

  modport slave (
    input  new_frame, shot_fired, hit, restart,
    output hex0, hex1, ammo_empty, game_over, reloading, reset_score
  );
endinterface

// File: rtl/ctl_ammo.sv
// Ammunition / game-round controller: PLAY -> EMPTY -> RELOAD -> PLAY with a
// BCD ammo count and a frame-paced reload animation.
// Ports: clk, rst (synchronous, active high), bus (ctl_ammo_if.slave).
// All outputs are registered; an input pulse at cycle N shows at cycle N+1.
module ctl_ammo #(
  parameter int unsigned START_TENS         = 3,
  parameter int unsigned START_ONES         = 4,
  parameter int unsigned HIT_BONUS          = 1,
  parameter int unsigned EMPTY_HOLD_FRAMES  = 120,
  parameter int unsigned RELOAD_STEP_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  ctl_ammo_if.slave   bus
);

  localparam int unsigned HOLD_W = $clog2(EMPTY_HOLD_FRAMES + 1);
  localparam int unsigned STEP_W = $clog2(RELOAD_STEP_FRAMES + 1);
  // One counter serves both EMPTY hold and RELOAD pacing; it is cleared on every state entry.
  localparam int unsigned FW     = (HOLD_W > STEP_W) ? HOLD_W : STEP_W;
  localparam logic [7:0]  START  = {4'(START_TENS), 4'(START_ONES)};
  localparam logic [3:0]  BONUS  = 4'(HIT_BONUS);

  typedef enum logic [1:0] {S_PLAY, S_EMPTY, S_RELOAD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      count_q, count_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            ammo_empty_q, game_over_q, reloading_q, reset_score_q;
  logic            ammo_empty_d, game_over_d, reloading_d, reset_score_d;

  // BCD add of a single digit, saturating at 99.
  function automatic logic [7:0] bcd_add(input logic [7:0] v, input logic [3:0] b);
    logic [4:0] o;
    logic [4:0] t;
    o = {1'b0, v[3:0]} + {1'b0, b};
    t = {1'b0, v[7:4]};
    if (o > 5'd9) begin
      o = o - 5'd10;
      t = t + 5'd1;
    end
    bcd_add = (t > 5'd9) ? 8'h99 : {t[3:0], o[3:0]};
  endfunction

  // BCD decrement by one, floor at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)
      bcd_dec = 8'h00;
    else if (v[3:0] == 4'd0)
      bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else
      bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  // State, count, frame counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_PLAY;
      count_q       <= START;
      frame_q       <= '0;
      ammo_empty_q  <= 1'b0;
      game_over_q   <= 1'b0;
      reloading_q   <= 1'b0;
      reset_score_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      frame_q       <= frame_d;
      ammo_empty_q  <= ammo_empty_d;
      game_over_q   <= game_over_d;
      reloading_q   <= reloading_d;
      reset_score_q <= reset_score_d;
    end
  end

  // Next state, next count and frame counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    frame_d = frame_q;
    unique case (state_q)
      S_PLAY: begin
        // Decrement first (only if nonzero), then bonus with saturation.
        if (bus.shot_fired && count_q != 8'h00) count_d = bcd_dec(count_d);
        if (bus.hit)                            count_d = bcd_add(count_d, BONUS);
        frame_d = '0;
        if (count_d == 8'h00) state_d = S_EMPTY;
      end
      S_EMPTY: begin
        if (bus.restart) begin
          state_d = S_RELOAD;
          frame_d = '0;
        end else if (bus.new_frame) begin
          if (frame_q == FW'(EMPTY_HOLD_FRAMES - 1)) begin
            state_d = S_RELOAD;
            frame_d = '0;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      S_RELOAD: begin
        if (bus.new_frame) begin
          if (frame_q == FW'(RELOAD_STEP_FRAMES - 1)) begin
            frame_d = '0;
            // A 00 magazine is already full: exit without incrementing.
            if (count_q == START) begin
              state_d = S_PLAY;
            end else begin
              count_d = bcd_add(count_q, 4'd1);
              if (count_d == START) state_d = S_PLAY;
            end
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      default: state_d = S_PLAY;
    endcase
  end

  // Next values of the registered flags, derived from the upcoming state/count.
  always_comb begin
    ammo_empty_d  = (count_d == 8'h00);
    game_over_d   = (state_d == S_EMPTY);
    reloading_d   = (state_d == S_RELOAD);
    reset_score_d = (state_q == S_EMPTY) && (state_d == S_RELOAD);
  end

  assign bus.hex1        = count_q[7:4];
  assign bus.hex0        = count_q[3:0];
  assign bus.ammo_empty  = ammo_empty_q;
  assign bus.game_over   = game_over_q;
  assign bus.reloading   = reloading_q;
  assign bus.reset_score = reset_score_q;

endmodule

// File: tb/tb_ctl_ammo.sv
// Directed bench for ctl_ammo with START=3:4, HIT_BONUS=1, EMPTY_HOLD_FRAMES=3,
// RELOAD_STEP_FRAMES=1. obs packs {hex1, hex0, ammo_empty, game_over, reloading, reset_score}.
module tb_ctl_ammo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  ctl_ammo_if bus();

  ctl_ammo #(
    .START_TENS(3), .START_ONES(4), .HIT_BONUS(1),
    .EMPTY_HOLD_FRAMES(3), .RELOAD_STEP_FRAMES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [11:0] obs;
  assign obs = {bus.hex1, bus.hex0, bus.ammo_empty, bus.game_over, bus.reloading, bus.reset_score};

  // One-cycle pulse driven on a falling edge; returns on the next falling edge.
  task automatic pulse(input logic sf, input logic h, input logic nf, input logic rs);
    @(negedge clk);
    bus.shot_fired = sf; bus.hit = h; bus.new_frame = nf; bus.restart = rs;
    @(negedge clk);
    bus.shot_fired = 1'b0; bus.hit = 1'b0; bus.new_frame = 1'b0; bus.restart = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (obs !== 12'h340) $display("FAIL reset: got %h want %h", obs, 12'h340); else passed++;
    total++;
  endtask

  task automatic test_shots;
    logic [11:0] exp_v [3];
    exp_v[0] = 12'h330; exp_v[1] = 12'h320; exp_v[2] = 12'h310;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      if (obs !== exp_v[i]) $display("FAIL shot%0d: got %h want %h", i, obs, exp_v[i]); else passed++;
      total++;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_bcd_borrow_carry;
    repeat (21) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    if (obs !== 12'h100) $display("FAIL preload10: got %h want %h", obs, 12'h100); else passed++;
    total++;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    if (obs !== 12'h090) $display("FAIL borrow10to09: got %h want %h", obs, 12'h090); else passed++;
    total++;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    if (obs !== 12'h100) $display("FAIL carry09to10: got %h want %h", obs, 12'h100); else passed++;
    total++;
  endtask

  task automatic test_saturate;
    repeat (89) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    if (obs !== 12'h990) $display("FAIL reach99: got %h want %h", obs, 12'h990); else passed++;
    total++;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    if (obs !== 12'h990) $display("FAIL sat99: got %h want %h", obs, 12'h990); else passed++;
    total++;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    if (obs !== 12'h990) $display("FAIL restart_in_play: got %h want %h", obs, 12'h990); else passed++;
    total++;
  endtask

  task automatic test_shot_and_hit;
    repeat (98) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    if (obs !== 12'h010) $display("FAIL preload01: got %h want %h", obs, 12'h010); else passed++;
    total++;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    if (obs !== 12'h010) $display("FAIL shot_hit_01: got %h want %h", obs, 12'h010); else passed++;
    total++;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    if (obs !== 12'h00C) $display("FAIL to_empty: got %h want %h", obs, 12'h00C); else passed++;
    total++;
  endtask

  task automatic test_empty_timeout;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h00C) $display("FAIL empty_nf1: got %h want %h", obs, 12'h00C); else passed++;
    total++;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    if (obs !== 12'h00C) $display("FAIL empty_shot: got %h want %h", obs, 12'h00C); else passed++;
    total++;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    if (obs !== 12'h00C) $display("FAIL empty_hit: got %h want %h", obs, 12'h00C); else passed++;
    total++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h00C) $display("FAIL empty_nf2: got %h want %h", obs, 12'h00C); else passed++;
    total++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h00B) $display("FAIL empty_nf3_exit: got %h want %h", obs, 12'h00B); else passed++;
    total++;
    @(negedge clk);
    if (obs !== 12'h00A) $display("FAIL score_pulse_len: got %h want %h", obs, 12'h00A); else passed++;
    total++;
  endtask

  task automatic test_reload;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h012) $display("FAIL reload_first: got %h want %h", obs, 12'h012); else passed++;
    total++;
    pulse(1'b1, 1'b1, 1'b0, 1'b1);
    if (obs !== 12'h012) $display("FAIL reload_ignore: got %h want %h", obs, 12'h012); else passed++;
    total++;
    repeat (8) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h092) $display("FAIL reload_09: got %h want %h", obs, 12'h092); else passed++;
    total++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h102) $display("FAIL reload_carry10: got %h want %h", obs, 12'h102); else passed++;
    total++;
    repeat (24) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h340) $display("FAIL reload_done: got %h want %h", obs, 12'h340); else passed++;
    total++;
  endtask

  task automatic test_restart;
    repeat (34) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    if (obs !== 12'h00C) $display("FAIL empty_again: got %h want %h", obs, 12'h00C); else passed++;
    total++;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    if (obs !== 12'h00B) $display("FAIL restart_exit: got %h want %h", obs, 12'h00B); else passed++;
    total++;
    @(negedge clk);
    if (obs !== 12'h00A) $display("FAIL restart_pulse_len: got %h want %h", obs, 12'h00A); else passed++;
    total++;
    repeat (34) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h340) $display("FAIL restart_reload34: got %h want %h", obs, 12'h340); else passed++;
    total++;
  endtask

  task automatic test_restart_with_frame;
    repeat (34) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    if (obs !== 12'h00B) $display("FAIL restart_nf_exit: got %h want %h", obs, 12'h00B); else passed++;
    total++;
    @(negedge clk);
    if (obs !== 12'h00A) $display("FAIL restart_nf_single: got %h want %h", obs, 12'h00A); else passed++;
    total++;
  endtask

  task automatic test_reset_mid_reload;
    repeat (17) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs !== 12'h172) $display("FAIL reload_17: got %h want %h", obs, 12'h172); else passed++;
    total++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (obs !== 12'h340) $display("FAIL mid_reset: got %h want %h", obs, 12'h340); else passed++;
    total++;
    @(negedge clk);
    if (obs !== 12'h340) $display("FAIL post_reset: got %h want %h", obs, 12'h340); else passed++;
    total++;
  endtask

  initial begin
    bus.shot_fired = 1'b0;
    bus.hit        = 1'b0;
    bus.new_frame  = 1'b0;
    bus.restart    = 1'b0;
    test_reset();
    test_shots();
    test_bcd_borrow_carry();
    test_saturate();
    test_shot_and_hit();
    test_empty_timeout();
    test_reload();
    test_restart();
    test_restart_with_frame();
    test_reset_mid_reload();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
